// File: rtl/i2s_rx_if.sv
// i2s_rx_if
// Bundles the three I2S serial lines and the rebuilt PCM outputs of the
// I2S receiver.
//   sclk, lrclk, sdata        serial I2S lines driven by the codec/ADC
//   left_chan, right_chan     last complete stereo pair, AUDIO_DW bits each
//   sample_valid              1-clk pulse when a new pair is on the outputs
//   len_err                   1-clk pulse on a committed word whose length is
//                             not AUDIO_DW (only with I2S_RX_STATUS_EN)
// Modports: slave is the receiver side, master is the codec/consumer side.
// Optional feature macro: I2S_RX_STATUS_EN.
interface i2s_rx_if #(
  parameter int AUDIO_DW = 16
);
  logic                sclk;
  logic                lrclk;
  logic                sdata;
  logic [AUDIO_DW-1:0] left_chan;
  logic [AUDIO_DW-1:0] right_chan;
  logic                sample_valid;
`ifdef I2S_RX_STATUS_EN
  logic                len_err;
`endif

  modport slave (
    input  sclk,
    input  lrclk,
    input  sdata,
    output left_chan,
    output right_chan,
    output sample_valid
`ifdef I2S_RX_STATUS_EN
    ,
    output len_err
`endif
  );

  modport master (
    output sclk,
    output lrclk,
    output sdata,
    input  left_chan,
    input  right_chan,
    input  sample_valid
`ifdef I2S_RX_STATUS_EN
    ,
    input  len_err
`endif
  );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx
// Standard (Philips) I2S slave receiver: MSB first, data delayed one bit
// clock after the word-select edge, lrclk=0 left, lrclk=1 right. The serial
// lines are asynchronous to clk and are oversampled; clk must be at least
// 4x sclk with sclk high and low for two or more clk periods.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   bus       i2s_rx_if.slave: sclk/lrclk/sdata in, left_chan/right_chan/
//             sample_valid (and len_err) out
// AUDIO_DW must match the AUDIO_DW of the connected interface.
// Optional feature macro: I2S_RX_STATUS_EN adds the len_err word-length
// status pulse; the data path is the same with or without it.
module i2s_rx #(
  parameter int AUDIO_DW = 16
) (
  input  logic    clk,
  input  logic    reset_n,
  i2s_rx_if.slave bus
);

  typedef enum logic [1:0] {
    LK_IDLE,   // no bit seen yet, channel of previous bit unknown
    LK_SEEK,   // waiting for the first word-select change
    LK_LOCKED  // aligned to word boundaries, words may be committed
  } lock_t;

  lock_t               lock_state;
  logic [1:0]          sclk_sync;
  logic [1:0]          lrclk_sync;
  logic [1:0]          sdata_sync;
  logic                sclk_d;
  logic                ch;
  logic                start_new;
  logic                have_left;
  logic [7:0]          bit_cnt;
  logic [AUDIO_DW-1:0] word;
  logic [AUDIO_DW-1:0] hold_l;
  logic [AUDIO_DW-1:0] left_q;
  logic [AUDIO_DW-1:0] right_q;
  logic                valid_q;

  logic                rise;
  logic                ws;
  logic                d;
  logic [AUDIO_DW-1:0] eff_word;
  logic [7:0]          eff_cnt;
  logic [AUDIO_DW-1:0] msb_bit;
  logic [AUDIO_DW-1:0] next_word;
  logic [7:0]          next_cnt;
  logic                word_end;
  logic                commit;

  // All three lines share the same synchronizer depth so that the lrclk and
  // sdata values seen in the rise cycle were captured together with sclk.
  assign rise = sclk_sync[1] & ~sclk_d;
  assign ws   = lrclk_sync[1];
  assign d    = sdata_sync[1];

  // Next-word computation for the current bit. A word that ended on the
  // previous rise is restarted here, so the new MSB lands in a clean word.
  // The incoming bit is placed by shifting a lone MSB right by the bit
  // count; bits past AUDIO_DW shift out and are dropped, and unreceived
  // LSBs stay zero.
  always_comb begin
    eff_word              = start_new ? '0 : word;
    eff_cnt               = start_new ? 8'd0 : bit_cnt;
    msb_bit               = '0;
    msb_bit[AUDIO_DW-1]   = d;
    next_word             = eff_word | (msb_bit >> eff_cnt);
    next_cnt              = (eff_cnt == 8'hFF) ? eff_cnt : eff_cnt + 8'd1;
    word_end              = (lock_state != LK_IDLE) && (ws != ch);
    commit                = rise && word_end && (lock_state == LK_LOCKED);
  end

  // Synchronizers, lock tracking, word assembly and output registers.
  // A left word is parked in hold_l and only released together with the
  // following right word, so a right word without a committed left partner
  // (first frame after lock) leaves the outputs alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_state <= LK_IDLE;
      sclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
      sclk_d     <= 1'b0;
      ch         <= 1'b0;
      start_new  <= 1'b0;
      have_left  <= 1'b0;
      bit_cnt    <= '0;
      word       <= '0;
      hold_l     <= '0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[0], bus.sclk};
      lrclk_sync <= {lrclk_sync[0], bus.lrclk};
      sdata_sync <= {sdata_sync[0], bus.sdata};
      sclk_d     <= sclk_sync[1];
      valid_q    <= 1'b0;
      if (rise) begin
        ch        <= ws;
        word      <= next_word;
        bit_cnt   <= next_cnt;
        start_new <= word_end;
        case (lock_state)
          LK_IDLE: lock_state <= LK_SEEK;
          LK_SEEK: if (word_end) lock_state <= LK_LOCKED;
          default: lock_state <= LK_LOCKED;
        endcase
        if (commit) begin
          if (!ch) begin
            hold_l    <= next_word;
            have_left <= 1'b1;
          end else begin
            have_left <= 1'b0;
            if (have_left) begin
              left_q  <= hold_l;
              right_q <= next_word;
              valid_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.left_chan    = left_q;
  assign bus.right_chan   = right_q;
  assign bus.sample_valid = valid_q;

`ifdef I2S_RX_STATUS_EN
  localparam logic [7:0] DW_CNT = 8'(AUDIO_DW);

  logic len_err_q;

  // Flags any committed word whose saturated length differs from AUDIO_DW;
  // the word itself is still committed in truncated/zero-padded form.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= commit && (next_cnt != DW_CNT);
    end
  end

  assign bus.len_err = len_err_q;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx
// Directed bench for i2s_rx: drives an I2S transmitter stream (lrclk and
// sdata change while sclk is low, sampled on sclk rise), queues the expected
// stereo pair whenever a complete left+right frame has been sent, and pops
// the queue on every sample_valid pulse. Covers reset, nominal data, sclk
// pause, long and short words, lrclk stall, reset mid-frame with relock,
// and a jittered bit clock with random data.
module tb_i2s_rx;

  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  logic clk = 1'b0;
  logic reset_n;

  i2s_rx_if #(.AUDIO_DW(DW)) bus ();

  i2s_rx #(.AUDIO_DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  int    total   = 0;
  int    bad     = 0;
  int    pushes  = 0;
  int    pulses  = 0;
  int    exp_len = 0;
  int    got_len = 0;
  pair_t sb_q[$];
  logic  pending_bit = 1'b0;
  logic  jitter      = 1'b0;
  logic  prev_sv     = 1'b0;
  time   t_mark      = 0;

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Half bit-clock period, nominal or jittered; never ends on a clk rising
  // edge so the synchronizer input is never racing the sampling edge.
  task automatic halfWait();
    int ns;
    ns = jitter ? int'($urandom_range(90, 50)) : 80;
    #(ns);
    if (($time % 20) == 10) #1;
  endtask

  // One sclk period carrying word-select ws and data bit d.
  task automatic applyStimulus(input logic ws, input logic d, input logic mark);
    bus.lrclk = ws;
    bus.sdata = d;
    halfWait();
    bus.sclk = 1'b1;
    if (mark) t_mark = $time;
    halfWait();
    bus.sclk = 1'b0;
  endtask

  // nbits periods with lrclk=ws. The first period carries the LSB of the
  // previous word (one-bit delay); the rest carry this word MSB first, and
  // this word's LSB is held back for the next call.
  task automatic sendWord(input logic ws, input logic [255:0] value, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i == 0) applyStimulus(ws, pending_bit, ws == 1'b0);
      else        applyStimulus(ws, value[8'(nbits - i)], 1'b0);
    end
    pending_bit = value[0];
  endtask

  // Expected channel value: top DW bits of the word, zero-padded if short.
  function automatic logic [DW-1:0] expChan(input logic [255:0] value, input int nbits);
    logic [255:0] v;
    if (nbits >= DW) v = value >> (nbits - DW);
    else             v = value << (DW - nbits);
    return v[DW-1:0];
  endfunction

  task automatic sendFrame(input logic [255:0] l, input int nl,
                           input logic [255:0] r, input int nr);
    pair_t e;
    sendWord(1'b0, l, nl);
    sendWord(1'b1, r, nr);
    e.l = expChan(l, nl);
    e.r = expChan(r, nr);
    sb_q.push_back(e);
    pushes++;
    if (nl != DW) exp_len++;
    if (nr != DW) exp_len++;
  endtask

  // Output monitor: every pulse must have a queued pair, match it, arrive a
  // few clk after the rise carrying the right LSB, and never be back to back.
  always @(negedge clk) begin
    pair_t e;
    if (reset_n === 1'b1) begin
      if (bus.sample_valid === 1'b1) begin
        pulses++;
        checkOutput("no_back_to_back", {63'd0, prev_sv}, 64'd0);
        checkOutput("pulse_has_expect", {63'd0, sb_q.size() != 0}, 64'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          checkOutput("left_chan", bus.left_chan, e.l);
          checkOutput("right_chan", bus.right_chan, e.r);
          checkOutput("latency_ok",
                      {63'd0, ($time - t_mark > 40) && ($time - t_mark <= 90)}, 64'd1);
        end
      end
`ifdef I2S_RX_STATUS_EN
      if (bus.len_err === 1'b1) got_len++;
`endif
    end
    prev_sv = bus.sample_valid;
  end

  initial begin
    logic [255:0] stall_word;
    logic [15:0]  rl;
    logic [15:0]  rr;
    pair_t        e;

    reset_n  = 1'b0;
    bus.sclk = 1'b0;
    bus.lrclk = 1'b0;
    bus.sdata = 1'b0;
    #25;
    checkOutput("reset_left", bus.left_chan, 64'd0);
    checkOutput("reset_right", bus.right_chan, 64'd0);
    checkOutput("reset_valid", {63'd0, bus.sample_valid}, 64'd0);
`ifdef I2S_RX_STATUS_EN
    checkOutput("reset_len_err", {63'd0, bus.len_err}, 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    #3;

    $display("[TB] nominal 16-bit frames");
    sendWord(1'b1, 256'd0, 16);
    for (int f = 0; f < 4; f++) sendFrame(256'h8001, 16, 256'h7FFE, 16);

    $display("[TB] sclk paused");
    repeat (100) @(posedge clk);
    #3;
    for (int f = 0; f < 2; f++) sendFrame(256'h8001, 16, 256'h7FFE, 16);

    $display("[TB] 24-bit words");
    for (int f = 0; f < 3; f++) sendFrame(256'hABCDEF, 24, 256'h123456, 24);

    $display("[TB] 8-bit words");
    for (int f = 0; f < 3; f++) sendFrame(256'hA5, 8, 256'h3C, 8);

    $display("[TB] lrclk stall");
    stall_word = 256'h8001;
    stall_word = stall_word << 200;
    sendWord(1'b0, stall_word, 216);
    checkOutput("stall_left_hold", bus.left_chan, 64'hA500);
    checkOutput("stall_right_hold", bus.right_chan, 64'h3C00);
    checkOutput("stall_pulses", 64'(pulses), 64'(pushes));
    sendWord(1'b1, 256'h7FFE, 16);
    e.l = 16'h8001;
    e.r = 16'h7FFE;
    sb_q.push_back(e);
    pushes++;
    exp_len++;

    $display("[TB] reset mid-frame");
    sendWord(1'b0, 256'h155, 10);
    repeat (5) @(posedge clk);
    #3;
    checkOutput("pre_reset_left", bus.left_chan, 64'h8001);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_left", bus.left_chan, 64'd0);
    checkOutput("midreset_right", bus.right_chan, 64'd0);
    checkOutput("midreset_valid", {63'd0, bus.sample_valid}, 64'd0);
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b1;
    sendWord(1'b0, 256'h0, 10);
    sendWord(1'b1, 256'h1111, 16);
    sendWord(1'b0, 256'h0F0F, 16);
    checkOutput("lone_right_no_update", bus.right_chan, 64'd0);
    checkOutput("lone_right_no_pulse", 64'(pulses), 64'(pushes));
    sendWord(1'b1, 256'hF0F0, 16);
    e.l = 16'h0F0F;
    e.r = 16'hF0F0;
    sb_q.push_back(e);
    pushes++;

    $display("[TB] jittered sclk, random data");
    jitter = 1'b1;
    for (int f = 0; f < 100; f++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      sendFrame(256'(rl), 16, 256'(rr), 16);
    end
    sendWord(1'b0, 256'h0, 4);
    jitter = 1'b0;

    repeat (20) @(posedge clk);
    #3;
    checkOutput("queue_drained", 64'(sb_q.size()), 64'd0);
    checkOutput("pulse_count", 64'(pulses), 64'(pushes));
`ifdef I2S_RX_STATUS_EN
    checkOutput("len_err_count", 64'(got_len), 64'(exp_len));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
